ans_freq_table: RTL and testbench



---
 rtl/ans_freq_table.sv | 136 +++++++++++++
 tb/tb_ans_freq_table.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ans_freq_table.sv
// ans_freq_table: per-symbol histogram plus a serially built inclusive cumulative table.
// Optional macro ANS_FREQ_NONZERO_EN floors every count to 1 during the prefix pass.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef SYM_COUNT
`define SYM_COUNT 16
`endif

module ans_freq_table #(
    parameter int unsigned SYM_WIDTH = `SYM_WIDTH,
    parameter int unsigned CNT_WIDTH = `CNT_WIDTH,
    parameter int unsigned SYM_COUNT = `SYM_COUNT
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       ena,
    input  logic [SYM_WIDTH-1:0]                       in,
    input  logic                                       in_last,
    input  logic                                       in_vld,
    output logic                                       in_rdy,
    input  logic                                       clear,
    output logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
    output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
    output logic                                       table_vld
);

    localparam int unsigned CumW = CNT_WIDTH + SYM_WIDTH;

    typedef enum logic [1:0] {StCount, StPrefix, StReady} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] counts_q [SYM_COUNT];
    logic [CNT_WIDTH-1:0] counts_d [SYM_COUNT];
    logic [CumW-1:0]      cum_q    [SYM_COUNT];
    logic [CumW-1:0]      cum_d    [SYM_COUNT];
    logic [CumW-1:0]      acc_q, acc_d;
    logic [SYM_WIDTH-1:0] idx_q, idx_d;
    logic                 rdy_q, rdy_d;
    logic                 vld_q, vld_d;
    logic [CNT_WIDTH-1:0] pre_cnt;
    logic [CumW-1:0]      pre_sum;
    logic                 sym_ok;

    always_comb begin
        state_d = state_q;
        counts_d = counts_q;
        cum_d = cum_q;
        acc_d = acc_q;
        idx_d = idx_q;
        rdy_d = rdy_q;
        vld_d = vld_q;
        sym_ok = (32'(in) < SYM_COUNT);
        pre_cnt = counts_q[idx_q];
`ifdef ANS_FREQ_NONZERO_EN
        if (pre_cnt == '0) pre_cnt = CNT_WIDTH'(1);
`endif
        pre_sum = acc_q + CumW'(pre_cnt);

        if (ena) begin
            if (clear) begin
                // Clear wins over any coincident handshake.
                for (int j = 0; j < int'(SYM_COUNT); j++) begin
                    counts_d[j] = '0;
                    cum_d[j] = '0;
                end
                acc_d = '0;
                idx_d = '0;
                rdy_d = 1'b1;
                vld_d = 1'b0;
                state_d = StCount;
            end else begin
                unique case (state_q)
                    StCount: begin
                        if (in_vld && rdy_q) begin
                            if (sym_ok && counts_q[in] != {CNT_WIDTH{1'b1}}) begin
                                counts_d[in] = counts_q[in] + CNT_WIDTH'(1);
                            end
                            if (in_last) begin
                                state_d = StPrefix;
                                rdy_d = 1'b0;
                                acc_d = '0;
                                idx_d = '0;
                            end
                        end
                    end
                    StPrefix: begin
                        counts_d[idx_q] = pre_cnt;
                        cum_d[idx_q] = pre_sum;
                        acc_d = pre_sum;
                        if (idx_q == SYM_WIDTH'(SYM_COUNT - 1)) begin
                            state_d = StReady;
                            vld_d = 1'b1;
                        end else begin
                            idx_d = idx_q + SYM_WIDTH'(1);
                        end
                    end
                    StReady: ;
                    default: state_d = StCount;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCount;
            counts_q <= '{default: '0};
            cum_q <= '{default: '0};
            acc_q <= '0;
            idx_q <= '0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            counts_q <= counts_d;
            cum_q <= cum_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            rdy_q <= rdy_d;
            vld_q <= vld_d;
        end
    end

    for (genvar j = 0; j < int'(SYM_COUNT); j++) begin : g_pack
        assign counts_unpacked[j*CNT_WIDTH +: CNT_WIDTH] = counts_q[j];
        assign cumulative_unpacked[j*CumW +: CumW] = cum_q[j];
    end

    assign in_rdy = rdy_q;
    assign table_vld = vld_q;

endmodule

// File: tb/tb_ans_freq_table.sv
// Randomized self-checking bench for ans_freq_table against a histogram/prefix-sum model.
// Honours ANS_FREQ_NONZERO_EN when the macro is defined for the build.
module tb_ans_freq_table;

    localparam int SW = 4;
    localparam int CW = 8;
    localparam int N  = 16;
    localparam int UW = CW + SW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [SW-1:0]     in;
    logic              in_last;
    logic              in_vld;
    logic              in_rdy;
    logic              clear;
    logic [CW*N-1:0]   counts_unpacked;
    logic [UW*N-1:0]   cumulative_unpacked;
    logic              table_vld;

    int total = 0;
    int bad = 0;
    int m_cnt [N];
    int m_cum [N];

    ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .SYM_COUNT(N)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ena                 (ena),
        .in                  (in),
        .in_last             (in_last),
        .in_vld              (in_vld),
        .in_rdy              (in_rdy),
        .clear               (clear),
        .counts_unpacked     (counts_unpacked),
        .cumulative_unpacked (cumulative_unpacked),
        .table_vld           (table_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cnt_at(input int j);
        return int'(counts_unpacked[j*CW +: CW]);
    endfunction

    function automatic int cum_at(input int j);
        return int'(cumulative_unpacked[j*UW +: UW]);
    endfunction

    function automatic void model_clear();
        for (int j = 0; j < N; j++) begin
            m_cnt[j] = 0;
            m_cum[j] = 0;
        end
    endfunction

    // Tables as the decoder expects them: optional floor, then running sum.
    function automatic void model_prefix();
        int acc = 0;
        for (int j = 0; j < N; j++) begin
`ifdef ANS_FREQ_NONZERO_EN
            if (m_cnt[j] == 0) m_cnt[j] = 1;
`endif
            acc += m_cnt[j];
            m_cum[j] = acc;
        end
    endfunction

    task automatic send(input int sym, input bit last, input bit vld);
        in = SW'(sym);
        in_last = last;
        in_vld = vld;
        if (vld && ena && in_rdy && m_cnt[sym] < 255) m_cnt[sym]++;
        @(negedge clk);
    endtask

    task automatic idle();
        in_vld = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        check("clear_vld", table_vld, 0);
        check("clear_counts_zero", counts_unpacked == '0, 1);
    endtask

    task automatic wait_tables(input string tag, input int lat0, input int exp_lat);
        int lat = lat0;
        while (!table_vld && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        model_prefix();
        for (int j = 0; j < N; j++) begin
            check($sformatf("%s_cnt%0d", tag, j), cnt_at(j), m_cnt[j]);
            check($sformatf("%s_cum%0d", tag, j), cum_at(j), m_cum[j]);
        end
        check({tag, "_rdy_low"}, in_rdy, 0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        ena = 1'b1;
        in = '0;
        in_last = 1'b0;
        in_vld = 1'b0;
        clear = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_rdy", in_rdy, 1);
        check("rst_vld", table_vld, 0);
        check("rst_counts_zero", counts_unpacked == '0, 1);
        check("rst_cum_zero", cumulative_unpacked == '0, 1);

        send(3, 0, 1); send(3, 0, 1); send(5, 0, 1); send(0, 1, 1);
        idle();
        wait_tables("basic", 0, 16);
`ifndef ANS_FREQ_NONZERO_EN
        check("basic_c3_const", cnt_at(3), 2);
        check("basic_u2_const", cum_at(2), 1);
        check("basic_u4_const", cum_at(4), 3);
        check("basic_u15_const", cum_at(15), 4);
`endif

        do_clear();
        repeat (300) send(7, 0, 1);
        send(7, 1, 1);
        idle();
        wait_tables("sat", 0, 16);
        check("sat_c7_const", cnt_at(7), 255);
`ifndef ANS_FREQ_NONZERO_EN
        check("sat_u15_const", cum_at(15), 255);
`endif

        do_clear();
        send(1, 0, 1); send(1, 0, 1);
        in = 4'd4;
        in_vld = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        send(9, 1, 1);
        idle();
        wait_tables("clrhs", 0, 16);
        check("clrhs_c4_const", cnt_at(4), 0);
`ifndef ANS_FREQ_NONZERO_EN
        check("clrhs_c1_const", cnt_at(1), 0);
        check("clrhs_u15_const", cum_at(15), 1);
`endif

        do_clear();
        send(2, 0, 1); send(6, 0, 1); send(6, 1, 1);
        idle();
        lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        ena = 1'b0;
        repeat (5) begin @(negedge clk); lat++; end
        check("ena_hold_vld", table_vld, 0);
        ena = 1'b1;
        wait_tables("ena", lat, 21);

`ifdef ANS_FREQ_NONZERO_EN
        do_clear();
        send(2, 0, 1); send(2, 1, 1);
        idle();
        wait_tables("nz", 0, 16);
        check("nz_c0_const", cnt_at(0), 1);
        check("nz_c2_const", cnt_at(2), 2);
        check("nz_u1_const", cum_at(1), 2);
        check("nz_u2_const", cum_at(2), 4);
        check("nz_u15_const", cum_at(15), 17);
`endif

        do_clear();
        send(4, 0, 1); send(4, 1, 1);
        idle();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rdy", in_rdy, 1);
        check("arst_vld", table_vld, 0);
        check("arst_counts_zero", counts_unpacked == '0, 1);
        check("arst_cum_zero", cumulative_unpacked == '0, 1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        for (int b = 0; b < 6; b++) begin
            int len = int'($urandom_range(1, 30));
            do_clear();
            for (int i = 0; i < len - 1; i++) begin
                bit v = ($urandom % 4) != 0;
                ena = ($urandom % 10) != 0;
                send(int'($urandom_range(0, N - 1)), v ? 1'b0 : 1'($urandom % 2), v);
            end
            ena = 1'b1;
            send(int'($urandom_range(0, N - 1)), 1'b1, 1'b1);
            idle();
            wait_tables($sformatf("rnd%0d", b), 0, 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
